// File: rtl/control_motores.sv
// Sequences three color motors (R, G, B) through an external phase timer.
// Each request runs R, then G, then B, with a watchdog per phase that latches a sticky error.
module control_motores #(
  parameter int TIMEOUT     = 20,
  parameter int SYNC_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       color_valid,
  output logic       color_ready,
  input  logic [7:0] color_r,
  input  logic [7:0] color_g,
  input  logic [7:0] color_b,
  output logic [4:0] ciclos_R,
  output logic [4:0] ciclos_G,
  output logic [4:0] ciclos_B,
  output logic       enter,
  input  logic [2:0] flags,
  output logic [2:0] motor,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int SW = (SYNC_CYCLES > 1) ? $clog2(SYNC_CYCLES) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    SYNC, IDLE, START, RUN_R, RUN_G, RUN_B, DONE, ERROR
  } state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] sync_cnt;
  logic [TW-1:0] phase_cnt;
  logic          handshake;
  logic          phase_timeout;
  logic          in_run;

  // The low nibble of each channel does not contribute to the cycle count.
  logic unused_low_bits;
  assign unused_low_bits = ^{color_r[3:0], color_g[3:0], color_b[3:0]};

  assign handshake     = (state == IDLE) && color_valid;
  assign phase_timeout = (phase_cnt == TW'(TIMEOUT - 1));
  assign in_run        = (state == RUN_R) || (state == RUN_G) || (state == RUN_B);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SYNC;
      sync_cnt  <= '0;
      phase_cnt <= '0;
      ciclos_R  <= '0;
      ciclos_G  <= '0;
      ciclos_B  <= '0;
    end else begin
      state <= state_nxt;
      if (state == SYNC)
        sync_cnt <= sync_cnt + 1'b1;
      // Counter restarts whenever a new phase begins.
      if (state_nxt != state)
        phase_cnt <= '0;
      else if (in_run)
        phase_cnt <= phase_cnt + 1'b1;
      if (handshake) begin
        ciclos_R <= {1'b0, color_r[7:4]};
        ciclos_G <= {1'b0, color_g[7:4]};
        ciclos_B <= {1'b0, color_b[7:4]};
      end
    end
  end

  // A phase flag wins over a timeout reached on the same edge.
  always_comb begin
    state_nxt = state;
    unique case (state)
      SYNC:  if (sync_cnt == SW'(SYNC_CYCLES - 1)) state_nxt = IDLE;
      IDLE:  if (color_valid) state_nxt = START;
      START: state_nxt = RUN_R;
      RUN_R: begin
        if (flags[2])           state_nxt = RUN_G;
        else if (phase_timeout) state_nxt = ERROR;
      end
      RUN_G: begin
        if (flags[1])           state_nxt = RUN_B;
        else if (phase_timeout) state_nxt = ERROR;
      end
      RUN_B: begin
        if (flags[0])           state_nxt = DONE;
        else if (phase_timeout) state_nxt = ERROR;
      end
      DONE:  state_nxt = IDLE;
      ERROR: state_nxt = ERROR;
      default: state_nxt = SYNC;
    endcase
  end

  always_comb begin
    color_ready = 1'b0;
    enter       = 1'b0;
    motor       = 3'b000;
    busy        = 1'b1;
    done        = 1'b0;
    error       = 1'b0;
    unique case (state)
      IDLE: begin
        color_ready = 1'b1;
        busy        = 1'b0;
      end
      START: enter    = 1'b1;
      RUN_R: motor[2] = (ciclos_R != 5'd0);
      RUN_G: motor[1] = (ciclos_G != 5'd0);
      RUN_B: motor[0] = (ciclos_B != 5'd0);
      DONE:  done     = 1'b1;
      ERROR: error    = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_motores.sv
// Directed bench for control_motores: table of color requests plus hand-written
// sequences for sync drain, timeout, flag-vs-timeout priority and mid-run reset.
module tb_control_motores;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       color_valid = 1'b0;
  logic       color_ready;
  logic [7:0] color_r = '0, color_g = '0, color_b = '0;
  logic [4:0] ciclos_R, ciclos_G, ciclos_B;
  logic       enter;
  logic [2:0] flags = '0;
  logic [2:0] motor;
  logic       busy, done, error;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  control_motores dut (
    .clk(clk), .rst(rst), .color_valid(color_valid), .color_ready(color_ready),
    .color_r(color_r), .color_g(color_g), .color_b(color_b),
    .ciclos_R(ciclos_R), .ciclos_G(ciclos_G), .ciclos_B(ciclos_B),
    .enter(enter), .flags(flags), .motor(motor),
    .busy(busy), .done(done), .error(error)
  );

  typedef struct {
    logic [7:0] r, g, b;
    logic [4:0] er, eg, eb;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      chk("rst_ready", color_ready, 0);
      chk("rst_enter", enter, 0);
      chk("rst_motor", motor, 0);
      chk("rst_busy", busy, 1);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
      chk("rst_cR", ciclos_R, 0);
      chk("rst_cG", ciclos_G, 0);
      chk("rst_cB", ciclos_B, 0);
    end
  endtask

  // Releases reset; ready must stay low for 64 cycles and rise exactly afterwards.
  task automatic sync_phase;
    rst = 1'b0;
    for (int i = 0; i < 64; i++) begin
      chk("sync_ready", color_ready, 0);
      chk("sync_busy", busy, 1);
      chk("sync_motor", motor, 0);
      tick();
    end
    chk("sync_ready_rise", color_ready, 1);
    chk("sync_idle_busy", busy, 0);
  endtask

  // One full request from IDLE; dr is the cycle index in RUN_R where flag R arrives.
  task automatic run_seq(input vec_t v, input int dr);
    logic [2:0] bitp;
    int c, d;
    chk("idle_ready", color_ready, 1);
    color_r = v.r; color_g = v.g; color_b = v.b;
    color_valid = 1'b1;
    tick();
    // Junk request held during busy must not be accepted.
    color_r = 8'hC3; color_g = 8'h5A; color_b = 8'h9F;
    chk("start_enter", enter, 1);
    chk("start_ready", color_ready, 0);
    chk("start_busy", busy, 1);
    chk("start_motor", motor, 0);
    chk("start_cR", ciclos_R, v.er);
    chk("start_cG", ciclos_G, v.eg);
    chk("start_cB", ciclos_B, v.eb);
    tick();
    for (int p = 0; p < 3; p++) begin
      bitp = 3'b100 >> p;
      c = (p == 0) ? int'(v.er) : (p == 1) ? int'(v.eg) : int'(v.eb);
      d = (p == 0) ? dr : c;
      for (int j = 0; j <= d; j++) begin
        flags = (j == d) ? bitp : (~bitp & 3'b111);
        chk("run_motor", motor, (c != 0) ? bitp : 3'b000);
        chk("run_enter", enter, 0);
        chk("run_done", done, 0);
        chk("run_ready", color_ready, 0);
        chk("run_cR", ciclos_R, v.er);
        chk("run_cG", ciclos_G, v.eg);
        chk("run_cB", ciclos_B, v.eb);
        tick();
      end
    end
    flags = 3'b000;
    chk("done_pulse", done, 1);
    chk("done_motor", motor, 0);
    chk("done_busy", busy, 1);
    color_valid = 1'b0;
    tick();
    chk("after_done", done, 0);
    chk("after_busy", busy, 0);
    chk("after_ready", color_ready, 1);
    chk("after_error", error, 0);
  endtask

  initial begin
    tbl[0] = '{r: 8'h50, g: 8'h20, b: 8'hF0, er: 5'd5,  eg: 5'd2,  eb: 5'd15};
    tbl[1] = '{r: 8'h80, g: 8'h0F, b: 8'h40, er: 5'd8,  eg: 5'd0,  eb: 5'd4};
    tbl[2] = '{r: 8'h00, g: 8'h00, b: 8'h00, er: 5'd0,  eg: 5'd0,  eb: 5'd0};
    tbl[3] = '{r: 8'hFF, g: 8'hFF, b: 8'hFF, er: 5'd15, eg: 5'd15, eb: 5'd15};
    tbl[4] = '{r: 8'h1C, g: 8'hA3, b: 8'h07, er: 5'd1,  eg: 5'd10, eb: 5'd0};

    // Reset held several cycles, then a request already pending through sync.
    color_r = tbl[0].r; color_g = tbl[0].g; color_b = tbl[0].b;
    apply_reset(3);
    color_valid = 1'b1;
    sync_phase();
    for (int i = 0; i < 5; i++)
      run_seq(tbl[i], int'(tbl[i].er));

    // Flag arriving on the timeout edge still advances the phase.
    run_seq(tbl[0], 19);

    // No flags at all: error after 20 cycles in RUN_R, sticky until reset.
    color_r = 8'h30; color_g = 8'h40; color_b = 8'h50;
    color_valid = 1'b1;
    tick();
    color_valid = 1'b0;
    chk("to_start_enter", enter, 1);
    tick();
    flags = 3'b000;
    for (int j = 0; j < 20; j++) begin
      chk("to_motor", motor, 3'b100);
      chk("to_error_early", error, 0);
      tick();
    end
    chk("to_error", error, 1);
    chk("to_motor_off", motor, 0);
    chk("to_busy", busy, 1);
    chk("to_ready", color_ready, 0);
    flags = 3'b111;
    color_valid = 1'b1;
    for (int j = 0; j < 5; j++) begin
      tick();
      chk("err_sticky", error, 1);
      chk("err_motor", motor, 0);
      chk("err_enter", enter, 0);
      chk("err_done", done, 0);
    end
    flags = 3'b000;
    color_valid = 1'b0;
    apply_reset(2);
    sync_phase();

    // Reset pulsed during RUN_G, then a fresh request completes.
    color_r = 8'h20; color_g = 8'h80; color_b = 8'h10;
    color_valid = 1'b1;
    tick();
    color_valid = 1'b0;
    tick();
    for (int j = 0; j <= 2; j++) begin
      flags = (j == 2) ? 3'b100 : 3'b000;
      chk("rg_runr_motor", motor, 3'b100);
      tick();
    end
    flags = 3'b000;
    chk("rg_rung_motor0", motor, 3'b010);
    tick();
    chk("rg_rung_motor1", motor, 3'b010);
    rst = 1'b1;
    tick();
    chk("rg_rst_motor", motor, 0);
    chk("rg_rst_busy", busy, 1);
    chk("rg_rst_ready", color_ready, 0);
    chk("rg_rst_error", error, 0);
    sync_phase();
    run_seq(tbl[1], int'(tbl[1].er));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
